// File: rtl/split_slave_ctrl.sv
// Slave-side sequencer for a split-capable bus slave: forwards one access at a
// time to a variable-latency memory and splits the bus transfer when the memory is slow.
module split_slave_ctrl #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int SPLIT_THRESH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              S_SEL,
  input  logic              S_VALID,
  input  logic [ADDR_W-1:0] S_ADDR,
  input  logic              S_WEN,
  input  logic [DATA_W-1:0] S_WDATA,
  input  logic              B_SPL_RESUME,
  output logic              S_SBSY,
  output logic              S_DONE,
  output logic              S_RVALID,
  output logic [DATA_W-1:0] S_RDATA,
  output logic              S_ERR,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WEN,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [2:0]        DBG_STATE
);

  localparam int CNT_W = $clog2(SPLIT_THRESH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPLIT_THRESH - 1);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_BUSY        = 3'd1,
    ST_SPLIT       = 3'd2,
    ST_RESUME_WAIT = 3'd3,
    ST_DONE        = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                sbsy_q, sbsy_d;
  logic                done_q, done_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                access;

  // Access handshake: an access is taken when S_SEL & S_VALID is sampled in
  // IDLE. There is no ready; an access seen in any other state is dropped and
  // reported by a one-cycle S_ERR pulse, leaving the in-flight access untouched.
  assign access = S_SEL & S_VALID;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    sbsy_d   = sbsy_q;
    done_d   = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = access && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          addr_d  = S_ADDR;
          wen_d   = S_WEN;
          wdata_d = S_WDATA;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // An ack arriving on the threshold edge still completes in place.
        if (MEM_ACK) begin
          req_d = 1'b0;
          if (!wen_q) rdata_d = MEM_RDATA;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          sbsy_d  = 1'b1;
          state_d = ST_SPLIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SPLIT: begin
        // Resume is only meaningful once the memory has finished.
        if (MEM_ACK) begin
          req_d = 1'b0;
          if (!wen_q) rdata_d = MEM_RDATA;
          if (B_SPL_RESUME) begin
            sbsy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RESUME_WAIT;
          end
        end
      end

      ST_RESUME_WAIT: begin
        if (B_SPL_RESUME) begin
          sbsy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done_d   = 1'b1;
        rvalid_d = !wen_q;
        sbsy_d   = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        sbsy_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      sbsy_q   <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      sbsy_q   <= sbsy_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign S_SBSY    = sbsy_q;
  assign S_DONE    = done_q;
  assign S_RVALID  = rvalid_q;
  assign S_RDATA   = rdata_q;
  assign S_ERR     = err_q;
  assign MEM_REQ   = req_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WEN   = wen_q;
  assign MEM_WDATA = wdata_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_split_slave_ctrl.sv
// Bench for split_slave_ctrl: each access is described by its ack edge and
// resume edge; expected waveforms are derived from those edges arithmetically.
module tb_split_slave_ctrl;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int T  = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          S_SEL, S_VALID, S_WEN, B_SPL_RESUME, MEM_ACK;
  logic [AW-1:0] S_ADDR;
  logic [DW-1:0] S_WDATA, MEM_RDATA;
  logic          S_SBSY, S_DONE, S_RVALID, S_ERR, MEM_REQ, MEM_WEN;
  logic [DW-1:0] S_RDATA, MEM_WDATA;
  logic [AW-1:0] MEM_ADDR;
  logic [2:0]    DBG_STATE;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd = '0;

  split_slave_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SPLIT_THRESH(T)) dut (
    .CLK(CLK), .RST(RST), .S_SEL(S_SEL), .S_VALID(S_VALID), .S_ADDR(S_ADDR),
    .S_WEN(S_WEN), .S_WDATA(S_WDATA), .B_SPL_RESUME(B_SPL_RESUME),
    .S_SBSY(S_SBSY), .S_DONE(S_DONE), .S_RVALID(S_RVALID), .S_RDATA(S_RDATA),
    .S_ERR(S_ERR), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_WEN(MEM_WEN),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // One access: k = edge of MEM_ACK after the access edge, r = first edge of
  // the held resume level (split only), errc = edge of a colliding access
  // (-1 none, 0 random). Checks every cycle through the S_DONE cycle.
  task automatic run_access(input logic wen, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] rd,
                            input int k, input int r, input int errc);
    logic split;
    int m, done_e, ec;
    logic [DW-1:0] exp_rd;
    split  = (k > T);
    m      = (split && r > k) ? r : k;
    done_e = m + 1;
    ec     = (errc == 0) ? int'($urandom_range(1, done_e)) : errc;
    if (!wen) exp_q.push_back(rd);
    S_SEL = 1'b1; S_VALID = 1'b1; S_ADDR = addr; S_WEN = wen; S_WDATA = wdata;
    MEM_ACK = 1'b0; B_SPL_RESUME = 1'b0;
    for (int e = 0; e <= done_e; e++) begin
      if (e > 0) begin
        S_SEL = (e == ec); S_VALID = (e == ec);
        S_ADDR = ~addr; S_WEN = ~wen; S_WDATA = ~wdata;
        MEM_ACK = (e == k);
        MEM_RDATA = (e == k) ? rd : DW'($urandom);
        B_SPL_RESUME = split && (r > 0) && (e >= r);
      end
      @(posedge CLK); #1;
      n_vec++;
      if (MEM_REQ !== (e < k)) begin
        n_err++; $display("FAIL mem_req e=%0d: got %b want %b", e, MEM_REQ, (e < k));
      end
      n_vec++;
      if ({MEM_ADDR, MEM_WEN, MEM_WDATA} !== {addr, wen, wdata}) begin
        n_err++; $display("FAIL mem_latch e=%0d: got %h/%b/%h want %h/%b/%h",
                          e, MEM_ADDR, MEM_WEN, MEM_WDATA, addr, wen, wdata);
      end
      n_vec++;
      if (S_DONE !== (e == done_e)) begin
        n_err++; $display("FAIL s_done e=%0d: got %b want %b", e, S_DONE, (e == done_e));
      end
      n_vec++;
      if (S_RVALID !== (e == done_e && !wen)) begin
        n_err++; $display("FAIL s_rvalid e=%0d: got %b want %b", e, S_RVALID, (e == done_e && !wen));
      end
      n_vec++;
      if (S_ERR !== (e == ec)) begin
        n_err++; $display("FAIL s_err e=%0d: got %b want %b", e, S_ERR, (e == ec));
      end
      if (!(split && e == m)) begin
        n_vec++;
        if (S_SBSY !== (split && e >= T && e < m)) begin
          n_err++; $display("FAIL s_sbsy e=%0d: got %b want %b", e, S_SBSY, (split && e >= T && e < m));
        end
      end
      if (e == done_e && !wen) begin
        exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : ~rd;
      end else begin
        exp_rd = (!wen && e >= k) ? rd : last_rd;
      end
      n_vec++;
      if (S_RDATA !== exp_rd) begin
        n_err++; $display("FAIL s_rdata e=%0d: got %h want %h", e, S_RDATA, exp_rd);
      end
    end
    if (!wen) last_rd = rd;
    S_SEL = 1'b0; S_VALID = 1'b0; MEM_ACK = 1'b0; B_SPL_RESUME = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; S_SEL = 0; S_VALID = 0; S_ADDR = '0; S_WEN = 0; S_WDATA = '0;
    B_SPL_RESUME = 0; MEM_ACK = 0; MEM_RDATA = '0;
    #12;
    n_vec++;
    if ({S_SBSY, S_DONE, S_RVALID, S_ERR, MEM_REQ, MEM_WEN} !== 6'b0 ||
        S_RDATA !== '0 || MEM_ADDR !== '0 || MEM_WDATA !== '0 || DBG_STATE !== 3'd0) begin
      n_err++; $display("FAIL reset_outputs: got sbsy%b done%b req%b rdata%h addr%h st%0d want all 0",
                        S_SBSY, S_DONE, MEM_REQ, S_RDATA, MEM_ADDR, DBG_STATE);
    end
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    n_vec++;
    if (MEM_REQ !== 1'b0 || DBG_STATE !== 3'd0) begin
      n_err++; $display("FAIL reset_release: got req%b st%0d want 0/0", MEM_REQ, DBG_STATE);
    end
  endtask

  task automatic test_fast_read();
    run_access(1'b0, 12'h010, 8'h00, 8'hA5, 2, -1, -1);
  endtask

  task automatic test_threshold_race();
    run_access(1'b1, 12'h222, 8'h5E, 8'h99, T, -1, -1);
  endtask

  task automatic test_split_read();
    run_access(1'b0, 12'h345, 8'h00, 8'h3C, 9, 14, -1);
  endtask

  task automatic test_early_resume();
    run_access(1'b0, 12'h100, 8'h00, 8'h5A, 8, 6, -1);
    run_access(1'b1, 12'h101, 8'hE1, 8'h00, 7, 7, -1);
  endtask

  task automatic test_error_access();
    run_access(1'b0, 12'h0F0, 8'h00, 8'hC3, 3, -1, 1);
    run_access(1'b1, 12'h0F1, 8'h12, 8'h00, 2, -1, 3);
  endtask

  task automatic test_reset_mid_split();
    S_SEL = 1; S_VALID = 1; S_ADDR = 12'h2A5; S_WEN = 0; S_WDATA = '0;
    for (int e = 0; e <= T + 3; e++) begin
      if (e > 0) begin
        S_SEL = 0; S_VALID = 0; MEM_ACK = (e == T + 1); MEM_RDATA = 8'h77;
      end
      @(posedge CLK); #1;
    end
    MEM_ACK = 0;
    n_vec++;
    if (S_SBSY !== 1'b1 || S_RDATA !== 8'h77) begin
      n_err++; $display("FAIL resume_wait_entry: got sbsy%b rdata%h want 1/77", S_SBSY, S_RDATA);
    end
    #2 RST = 1'b1;
    #1;
    n_vec++;
    if (S_SBSY !== 1'b0 || MEM_REQ !== 1'b0 || S_DONE !== 1'b0 || DBG_STATE !== 3'd0) begin
      n_err++; $display("FAIL reset_mid_split: got sbsy%b req%b done%b st%0d want 0/0/0/0",
                        S_SBSY, MEM_REQ, S_DONE, DBG_STATE);
    end
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    n_vec++;
    if (DBG_STATE !== 3'd0 || S_SBSY !== 1'b0 || S_DONE !== 1'b0) begin
      n_err++; $display("FAIL after_reset_split: got st%0d sbsy%b done%b want 0/0/0", DBG_STATE, S_SBSY, S_DONE);
    end
    last_rd = '0;
    // reset with the memory request still outstanding
    S_SEL = 1; S_VALID = 1; S_ADDR = 12'h3B0; S_WEN = 1; S_WDATA = 8'h44;
    @(posedge CLK); #1;
    S_SEL = 0; S_VALID = 0;
    @(posedge CLK); #1;
    n_vec++;
    if (MEM_REQ !== 1'b1) begin
      n_err++; $display("FAIL busy_req: got %b want 1", MEM_REQ);
    end
    #2 RST = 1'b1;
    #1;
    n_vec++;
    if (MEM_REQ !== 1'b0 || DBG_STATE !== 3'd0) begin
      n_err++; $display("FAIL reset_mid_busy: got req%b st%0d want 0/0", MEM_REQ, DBG_STATE);
    end
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    run_access(1'b0, 12'h3B1, 8'h00, 8'h6D, 1, -1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic wen;
      int k, r, ec;
      wen = 1'($urandom);
      k   = $urandom_range(1, 12);
      r   = (k > T) ? int'($urandom_range(1, k + 6)) : -1;
      ec  = ($urandom_range(0, 3) == 0) ? 0 : -1;
      run_access(wen, AW'($urandom), DW'($urandom), DW'($urandom), k, r, ec);
    end
  endtask

  initial begin
    test_reset();
    test_fast_read();
    test_threshold_race();
    test_split_read();
    test_early_resume();
    test_error_access();
    test_reset_mid_split();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
